// File: rtl/div_arb_pkg.sv
// Shared types and defaults for the two-requester divider arbiter.
package div_arb_pkg;

  localparam int DIV_ARB_WIDTH   = 32;
  localparam int DIV_ARB_TIMEOUT = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef logic [0:0] grant_id_t;

  localparam grant_id_t GRANT_REQ0 = 1'b0;
  localparam grant_id_t GRANT_REQ1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant selection; purely combinational.
module rr_arb2
  import div_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant
);

  // On contention the requester that was not served last wins.
  always_comb begin
    grant = GRANT_REQ0;
    if (req0 && req1) begin
      grant = ~last_grant;
    end else if (req1) begin
      grant = GRANT_REQ1;
    end else begin
      grant = GRANT_REQ0;
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Shares one divider between two requesters: IDLE -> ISSUE -> WAIT -> DONE.
// Optional WAIT watchdog enabled by defining DIV_ARB_TIMEOUT_EN.
module div_arbiter
  import div_arb_pkg::*;
#(
  parameter int WIDTH   = DIV_ARB_WIDTH,
  parameter int TIMEOUT = DIV_ARB_TIMEOUT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] dividend0,
  input  logic [WIDTH-1:0] dividend1,
  input  logic [WIDTH-1:0] divisor0,
  input  logic [WIDTH-1:0] divisor1,
  output logic             ack0,
  output logic             ack1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic             exception,
  output logic             busy,
  output logic             timeout,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  output logic             div_ctrl,
  input  logic [WIDTH-1:0] div_result,
  input  logic             div_exception,
  input  logic             div_ready
);

  state_t           state_r, state_s;
  grant_id_t        grant_r, grant_s;
  grant_id_t        last_grant_r, last_grant_s;
  logic             arb_grant_s;
  logic             issue_s, finish_s, timeout_hit_s;
  logic             ack0_r, ack1_r, done0_r, done1_r, busy_r, timeout_r, div_ctrl_r;
  logic             ack0_s, ack1_s, done0_s, done1_s, busy_s, timeout_s;
  logic             exception_r, exception_s;
  logic [WIDTH-1:0] result_r, result_s;
  logic [WIDTH-1:0] dividend_r, dividend_s;
  logic [WIDTH-1:0] divisor_r, divisor_s;

  rr_arb2 u_rr_arb2 (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant_r),
    .grant      (arb_grant_s)
  );

`ifdef DIV_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt_r;

  // WAIT-cycle counter, restarted on every pass through ISSUE.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wait_cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == ST_ISSUE) begin
      wait_cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == ST_WAIT) begin
      wait_cnt_r <= wait_cnt_r + CNT_W'(1);
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  assign timeout_hit_s = (state_r == ST_WAIT) && (wait_cnt_r == CNT_W'(TIMEOUT - 1));
`else
  assign timeout_hit_s = 1'b0;
`endif

  // Next state plus next value of every registered output.
  always_comb begin
    state_s      = state_r;
    grant_s      = grant_r;
    last_grant_s = last_grant_r;
    dividend_s   = dividend_r;
    divisor_s    = divisor_r;
    result_s     = result_r;
    exception_s  = exception_r;
    timeout_s    = 1'b0;
    issue_s      = 1'b0;
    finish_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req0 || req1) begin
          state_s      = ST_ISSUE;
          issue_s      = 1'b1;
          grant_s      = arb_grant_s;
          last_grant_s = arb_grant_s;
          if (arb_grant_s == GRANT_REQ1) begin
            dividend_s = dividend1;
            divisor_s  = divisor1;
          end else begin
            dividend_s = dividend0;
            divisor_s  = divisor0;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: state_s = ST_WAIT;
      ST_WAIT: begin
        // A real divider answer beats the watchdog in the same cycle.
        if (div_ready) begin
          state_s     = ST_DONE;
          finish_s    = 1'b1;
          result_s    = div_result;
          exception_s = div_exception;
        end else if (timeout_hit_s) begin
          state_s     = ST_DONE;
          finish_s    = 1'b1;
          result_s    = {WIDTH{1'b0}};
          exception_s = 1'b1;
          timeout_s   = 1'b1;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
    ack0_s  = issue_s && (grant_s == GRANT_REQ0);
    ack1_s  = issue_s && (grant_s == GRANT_REQ1);
    done0_s = finish_s && (grant_r == GRANT_REQ0);
    done1_s = finish_s && (grant_r == GRANT_REQ1);
    busy_s  = (state_s != ST_IDLE);
  end

  // State and output registers; the last-grant pointer resets to 1 so requester 0 wins first.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      grant_r      <= GRANT_REQ0;
      last_grant_r <= GRANT_REQ1;
      ack0_r       <= 1'b0;
      ack1_r       <= 1'b0;
      done0_r      <= 1'b0;
      done1_r      <= 1'b0;
      busy_r       <= 1'b0;
      timeout_r    <= 1'b0;
      div_ctrl_r   <= 1'b0;
      exception_r  <= 1'b0;
      result_r     <= {WIDTH{1'b0}};
      dividend_r   <= {WIDTH{1'b0}};
      divisor_r    <= {WIDTH{1'b0}};
    end else begin
      state_r      <= state_s;
      grant_r      <= grant_s;
      last_grant_r <= last_grant_s;
      ack0_r       <= ack0_s;
      ack1_r       <= ack1_s;
      done0_r      <= done0_s;
      done1_r      <= done1_s;
      busy_r       <= busy_s;
      timeout_r    <= timeout_s;
      div_ctrl_r   <= issue_s;
      exception_r  <= exception_s;
      result_r     <= result_s;
      dividend_r   <= dividend_s;
      divisor_r    <= divisor_s;
    end
  end

  assign ack0         = ack0_r;
  assign ack1         = ack1_r;
  assign done0        = done0_r;
  assign done1        = done1_r;
  assign busy         = busy_r;
  assign timeout      = timeout_r;
  assign div_ctrl     = div_ctrl_r;
  assign exception    = exception_r;
  assign result       = result_r;
  assign div_dividend = dividend_r;
  assign div_divisor  = divisor_r;

endmodule

// File: tb/tb_div_arbiter.sv
// Directed self-checking bench for div_arbiter with a behavioural divider and requester model.
module tb_div_arbiter;

  localparam int W  = 32;
  localparam int TO = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         req0, req1;
  logic [W-1:0] dividend0, dividend1, divisor0, divisor1;
  logic         ack0, ack1, done0, done1;
  logic [W-1:0] result;
  logic         exception, busy, timeout;
  logic [W-1:0] div_dividend, div_divisor;
  logic         div_ctrl;
  logic [W-1:0] div_result;
  logic         div_exception, div_ready;

  div_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1),
    .dividend0(dividend0), .dividend1(dividend1),
    .divisor0(divisor0), .divisor1(divisor1),
    .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
    .result(result), .exception(exception), .busy(busy), .timeout(timeout),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .div_ctrl(div_ctrl),
    .div_result(div_result), .div_exception(div_exception), .div_ready(div_ready)
  );

  always #5 clock = ~clock;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int n_ack0, n_ack1, n_done0, n_done1, n_ctrl;
  int grant_q[$];
  int ack_cyc_q[$];
  int done_id_q[$];
  int done_cyc_q[$];
  logic [W-1:0] res_q[$];
  logic exc_q[$];
  logic to_q[$];
  bit hold, model_en, pend;
  int dly, cnt;
  logic [W-1:0] cap_a, cap_b;

  task automatic clear_log();
    n_ack0 = 0; n_ack1 = 0; n_done0 = 0; n_done1 = 0; n_ctrl = 0;
    grant_q.delete(); ack_cyc_q.delete(); done_id_q.delete(); done_cyc_q.delete();
    res_q.delete(); exc_q.delete(); to_q.delete();
  endtask

  // Pad logs so indexed reads stay in range when the DUT under-delivers.
  task automatic pad_logs(input int n);
    while (grant_q.size() < n) begin grant_q.push_back(-1); ack_cyc_q.push_back(-1); end
    while (res_q.size() < n) begin
      res_q.push_back('x); exc_q.push_back(1'bx); to_q.push_back(1'bx);
      done_id_q.push_back(-1); done_cyc_q.push_back(-1);
    end
  endtask

  // One clock: observe outputs at negedge, then play requester and divider.
  task automatic step();
    @(negedge clock);
    cyc++;
    if (ack0) begin n_ack0++; grant_q.push_back(0); ack_cyc_q.push_back(cyc); if (!hold) req0 = 1'b0; end
    if (ack1) begin n_ack1++; grant_q.push_back(1); ack_cyc_q.push_back(cyc); if (!hold) req1 = 1'b0; end
    if (div_ctrl) n_ctrl++;
    if (done0 || done1) begin
      done_id_q.push_back(done1 ? 1 : 0);
      res_q.push_back(result); exc_q.push_back(exception); to_q.push_back(timeout);
      done_cyc_q.push_back(cyc);
      if (done0) n_done0++;
      if (done1) n_done1++;
    end
    if (div_ready) div_ready = 1'b0;
    if (div_ctrl) begin
      pend = 1'b1; cnt = dly; cap_a = div_dividend; cap_b = div_divisor;
    end else if (pend && model_en) begin
      cnt--;
      if (cnt <= 0) begin
        pend = 1'b0;
        div_ready = 1'b1;
        if (cap_b == '0) begin
          div_result = '0; div_exception = 1'b1;
        end else begin
          div_result = W'($signed(cap_a) / $signed(cap_b)); div_exception = 1'b0;
        end
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; req0 = 1'b0; req1 = 1'b0; div_ready = 1'b0;
    pend = 1'b0; hold = 1'b0; model_en = 1'b1;
    repeat (3) step();
    reset = 1'b1;
    step();
    clear_log();
  endtask

  task automatic wait_dones(input int n, input int budget, output bit ok);
    int k = 0;
    while ((n_done0 + n_done1) < n && k < budget) begin step(); k++; end
    ok = ((n_done0 + n_done1) >= n);
  endtask

  task automatic wait_ack(input int budget);
    int k = 0;
    while ((n_ack0 + n_ack1) == 0 && k < budget) begin step(); k++; end
  endtask

  task automatic test_reset();
    reset = 1'b0; req0 = 1'b1; req1 = 1'b1;
    dividend0 = 32'd11; divisor0 = 32'd2; dividend1 = 32'd13; divisor1 = 32'd3;
    div_result = 32'hDEAD_BEEF; div_exception = 1'b1; div_ready = 1'b1;
    pend = 1'b0; model_en = 1'b0; hold = 1'b1;
    repeat (3) step();
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if ({ack0, ack1, done0, done1, div_ctrl} !== 5'b0)
      $display("FAIL reset_pulses: got %b want 00000", {ack0, ack1, done0, done1, div_ctrl}); else pass_cnt++;
    total_cnt++; if ({timeout, exception} !== 2'b00) $display("FAIL reset_flags: got %b want 00", {timeout, exception}); else pass_cnt++;
    total_cnt++; if (result !== 32'd0) $display("FAIL reset_result: got %h want 0", result); else pass_cnt++;
    total_cnt++; if ({div_dividend, div_divisor} !== 64'd0)
      $display("FAIL reset_div_ops: got %h %h want 0 0", div_dividend, div_divisor); else pass_cnt++;
    hold = 1'b0;
  endtask

  task automatic test_single();
    int base;
    bit ok;
    do_reset();
    dly = 24; dividend0 = 32'd100; divisor0 = 32'd7; req0 = 1'b1; base = cyc;
    wait_ack(10);
    dividend0 = 32'd555; divisor0 = 32'd1;
    wait_dones(1, 100, ok);
    pad_logs(1);
    total_cnt++; if (!ok) $display("FAIL single_done_seen: got %0d dones want 1", n_done0 + n_done1); else pass_cnt++;
    total_cnt++; if (ack_cyc_q[0] - base !== 1) $display("FAIL single_ack_cycle: got %0d want 1", ack_cyc_q[0] - base); else pass_cnt++;
    total_cnt++; if (done_cyc_q[0] - base !== 26) $display("FAIL single_latency: got %0d want 26", done_cyc_q[0] - base); else pass_cnt++;
    total_cnt++; if (done_id_q[0] !== 0) $display("FAIL single_done_id: got %0d want 0", done_id_q[0]); else pass_cnt++;
    total_cnt++; if (res_q[0] !== 32'd14) $display("FAIL single_result: got %0d want 14", res_q[0]); else pass_cnt++;
    total_cnt++; if ({exc_q[0], to_q[0]} !== 2'b00) $display("FAIL single_flags: got %b want 00", {exc_q[0], to_q[0]}); else pass_cnt++;
    repeat (3) step();
    total_cnt++; if (n_ctrl !== 1) $display("FAIL single_ctrl_count: got %0d want 1", n_ctrl); else pass_cnt++;
    total_cnt++; if ({n_ack0, n_done0} !== {32'd1, 32'd1}) $display("FAIL single_pulse_counts: got ack %0d done %0d want 1 1", n_ack0, n_done0); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL single_idle_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (result !== 32'd14) $display("FAIL single_result_held: got %0d want 14", result); else pass_cnt++;
  endtask

  task automatic test_both();
    bit ok;
    do_reset();
    dly = 3;
    dividend0 = 32'd20; divisor0 = 32'd4; dividend1 = -32'sd21; divisor1 = 32'd3;
    req0 = 1'b1; req1 = 1'b1;
    wait_dones(2, 200, ok);
    pad_logs(2);
    total_cnt++; if (!ok) $display("FAIL both_done_seen: got %0d want 2", n_done0 + n_done1); else pass_cnt++;
    total_cnt++; if ({grant_q[0], grant_q[1]} !== {32'd0, 32'd1}) $display("FAIL both_order: got %0d,%0d want 0,1", grant_q[0], grant_q[1]); else pass_cnt++;
    total_cnt++; if (res_q[0] !== 32'd5) $display("FAIL both_result0: got %0d want 5", $signed(res_q[0])); else pass_cnt++;
    total_cnt++; if (res_q[1] !== 32'hFFFF_FFF9) $display("FAIL both_result1: got %0d want -7", $signed(res_q[1])); else pass_cnt++;
    total_cnt++; if (done_id_q[1] !== 1) $display("FAIL both_done_id1: got %0d want 1", done_id_q[1]); else pass_cnt++;
    total_cnt++; if (ack_cyc_q[1] !== done_cyc_q[0] + 2) $display("FAIL both_no_overlap: ack1 at %0d want %0d", ack_cyc_q[1], done_cyc_q[0] + 2); else pass_cnt++;
  endtask

  task automatic test_div_zero();
    bit ok;
    do_reset();
    dly = 2; dividend1 = 32'd9; divisor1 = 32'd0; req1 = 1'b1;
    wait_dones(1, 50, ok);
    repeat (3) step();
    pad_logs(1);
    total_cnt++; if (!ok) $display("FAIL dz_done_seen: got %0d want 1", n_done1); else pass_cnt++;
    total_cnt++; if ({done_id_q[0], 31'd0, exc_q[0]} !== {32'd1, 32'd1}) $display("FAIL dz_exception: id %0d exc %b want 1 1", done_id_q[0], exc_q[0]); else pass_cnt++;
    total_cnt++; if ({n_ack0, n_done0} !== 64'd0) $display("FAIL dz_req0_silent: got ack0 %0d done0 %0d want 0 0", n_ack0, n_done0); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    model_en = 1'b0; dly = 2; dividend0 = 32'd40; divisor0 = 32'd8; req0 = 1'b1;
    wait_ack(10);
    repeat (6) step();
    total_cnt++; if (busy !== 1'b1) $display("FAIL mid_busy_in_wait: got %b want 1", busy); else pass_cnt++;
    reset = 1'b0;
    step();
    reset = 1'b1; pend = 1'b0;
    div_result = 32'd77; div_exception = 1'b1; div_ready = 1'b1;
    repeat (5) step();
    total_cnt++; if (n_done0 + n_done1 !== 0) $display("FAIL mid_no_done: got %0d want 0", n_done0 + n_done1); else pass_cnt++;
    total_cnt++; if ({busy, exception, timeout} !== 3'b000) $display("FAIL mid_flags: got %b want 000", {busy, exception, timeout}); else pass_cnt++;
    total_cnt++; if ({result, div_dividend, div_divisor} !== 96'd0)
      $display("FAIL mid_data: got %h %h %h want 0", result, div_dividend, div_divisor); else pass_cnt++;
    clear_log(); model_en = 1'b1;
    dividend0 = 32'd50; divisor0 = 32'd5; req0 = 1'b1;
    wait_dones(1, 50, ok);
    pad_logs(1);
    total_cnt++; if ({done_id_q[0], res_q[0]} !== {32'd0, 32'd10}) $display("FAIL mid_next_op: id %0d result %0d want 0 10", done_id_q[0], res_q[0]); else pass_cnt++;
  endtask

  task automatic test_alternate();
    bit ok;
    do_reset();
    dly = 1; hold = 1'b1;
    dividend0 = 32'd12; divisor0 = 32'd3; dividend1 = 32'd30; divisor1 = 32'd6;
    req0 = 1'b1; req1 = 1'b1;
    wait_dones(4, 300, ok);
    hold = 1'b0; req0 = 1'b0; req1 = 1'b0;
    repeat (4) step();
    pad_logs(4);
    total_cnt++; if (!ok) $display("FAIL alt_done_seen: got %0d want 4", n_done0 + n_done1); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (grant_q[i] !== (i % 2)) $display("FAIL alt_grant_%0d: got %0d want %0d", i, grant_q[i], i % 2); else pass_cnt++;
      total_cnt++;
      if (res_q[i] !== ((i % 2) ? 32'd5 : 32'd4)) $display("FAIL alt_result_%0d: got %0d want %0d", i, res_q[i], (i % 2) ? 5 : 4); else pass_cnt++;
    end
    total_cnt++; if (n_ack0 + n_ack1 !== 4) $display("FAIL alt_ack_total: got %0d want 4", n_ack0 + n_ack1); else pass_cnt++;
  endtask

`ifdef DIV_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    do_reset();
    model_en = 1'b0; dividend0 = 32'd5; divisor0 = 32'd1; req0 = 1'b1;
    wait_dones(1, 100, ok);
    pad_logs(1);
    total_cnt++; if (done_cyc_q[0] - ack_cyc_q[0] !== 33) $display("FAIL to_wait_cycles: got %0d want 33", done_cyc_q[0] - ack_cyc_q[0]); else pass_cnt++;
    total_cnt++; if ({res_q[0], exc_q[0], to_q[0]} !== {32'd0, 2'b11}) $display("FAIL to_outputs: result %0d exc %b to %b want 0 1 1", res_q[0], exc_q[0], to_q[0]); else pass_cnt++;
    do_reset();
    dly = 32; req0 = 1'b1;
    wait_dones(1, 100, ok);
    pad_logs(1);
    total_cnt++; if ({res_q[0], exc_q[0], to_q[0]} !== {32'd5, 2'b00}) $display("FAIL to_ready_wins: result %0d exc %b to %b want 5 0 0", res_q[0], exc_q[0], to_q[0]); else pass_cnt++;
  endtask
`else
  task automatic test_wait_hold();
    bit ok;
    do_reset();
    model_en = 1'b0; dividend0 = 32'd7; divisor0 = 32'd7; req0 = 1'b1;
    wait_ack(10);
    repeat (60) step();
    total_cnt++; if ({busy, 31'd0, n_done0} !== {1'b1, 31'd0, 32'd0}) $display("FAIL hold_still_waiting: busy %b dones %0d want 1 0", busy, n_done0); else pass_cnt++;
    pend = 1'b0; div_result = 32'd1; div_exception = 1'b0; div_ready = 1'b1;
    wait_dones(1, 5, ok);
    pad_logs(1);
    total_cnt++; if ({res_q[0], to_q[0]} !== {32'd1, 1'b0}) $display("FAIL hold_result: result %0d to %b want 1 0", res_q[0], to_q[0]); else pass_cnt++;
  endtask
`endif

  initial begin
    reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
    dividend0 = '0; dividend1 = '0; divisor0 = '0; divisor1 = '0;
    div_result = '0; div_exception = 1'b0; div_ready = 1'b0;
    dly = 1; cnt = 0; pend = 1'b0; hold = 1'b0; model_en = 1'b1;
    cap_a = '0; cap_b = '0;
    clear_log();
    test_reset();
    test_single();
    test_both();
    test_div_zero();
    test_reset_mid();
    test_alternate();
`ifdef DIV_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_wait_hold();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand, result and divider-port width.
REQ-002 SHALL have parameter TIMEOUT, default 32: maximum WAIT cycles when DIV_ARB_TIMEOUT_EN is defined.
REQ-003 SHALL have port clock  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-005 SHALL have ports req0/req1  in  1  requester N wants a divide; held high until ackN.
REQ-006 SHALL have ports dividend0/dividend1, divisor0/divisor1  in  WIDTH  requester N operands; held stable until ackN.
REQ-007 SHALL have ports ack0/ack1  out  1  one-cycle pulse: requester N operands captured.
REQ-008 SHALL have ports done0/done1  out  1  one-cycle pulse: result and exception valid for requester N.
REQ-009 SHALL have ports result  out  WIDTH and exception  out  1: shared return bus, held until the next done.
REQ-010 SHALL have port busy  out  1  high in every state except IDLE.
REQ-011 SHALL have port timeout  out  1  high with done when the operation timed out; tied 0 without the macro.
REQ-012 SHALL have ports div_dividend/div_divisor  out  WIDTH  registered operands driven to the divider.
REQ-013 SHALL have port div_ctrl  out  1  one-cycle divider start strobe.
REQ-014 SHALL have ports div_result  in  WIDTH, div_exception  in  1, div_ready  in  1: divider outputs.

Function
REQ-015 SHALL implement FSM IDLE -> ISSUE -> WAIT -> DONE -> IDLE, one state per cycle except WAIT.
REQ-016 IDLE: if any req is high at the edge, SHALL latch the grant id and that requester's operands into div_dividend/div_divisor, then enter ISSUE; otherwise stay in IDLE.
REQ-017 ISSUE: SHALL assert ackN for the granted N and assert div_ctrl, for exactly this one cycle, then enter WAIT.
REQ-018 WAIT: SHALL sample div_ready only in this state; when it is high, SHALL latch div_result and div_exception and enter DONE.
REQ-019 DONE: SHALL assert doneN for the granted N for one cycle, with result and exception valid, then enter IDLE.
REQ-020 Arbitration SHALL be 2-way round-robin: on simultaneous req0 and req1, the requester not granted last wins; after reset, requester 0 wins.
REQ-021 A request raised while busy SHALL stay pending, with no ack, until IDLE.
REQ-022 A requester holding req high after its done SHALL be eligible again in the next IDLE, subject to round-robin.
REQ-023 Minimum request-to-done latency SHALL be 3 cycles plus the number of WAIT cycles.
REQ-024 Operand changes after ack SHALL have no effect on the operation in flight.
REQ-025 div_exception (divide by zero) SHALL be passed through to exception unmodified; the arbiter SHALL NOT detect it independently.

Reset
REQ-026 With reset low at the edge, the FSM SHALL enter IDLE and clear the round-robin pointer to favour requester 0.
REQ-027 With reset low at the edge, ack*, done*, div_ctrl, busy, timeout, exception, result, div_dividend and div_divisor SHALL all be 0.
REQ-028 Reset mid-operation SHALL discard the operation in flight: no done is issued, and a later div_ready is ignored because the FSM is in IDLE.

Configuration
REQ-029 With DIV_ARB_TIMEOUT_EN defined, a counter SHALL clear on WAIT entry and count WAIT cycles.
REQ-030 With DIV_ARB_TIMEOUT_EN defined, reaching TIMEOUT cycles with div_ready low SHALL enter DONE with result=0, exception=1 and timeout=1.
REQ-031 With DIV_ARB_TIMEOUT_EN defined, if div_ready and the timeout occur in the same cycle, div_ready SHALL win.
REQ-032 Without DIV_ARB_TIMEOUT_EN, WAIT SHALL persist until div_ready, no counter SHALL exist, and timeout SHALL be constant 0.

Structure
REQ-033 Package div_arb_pkg SHALL hold the FSM state enumeration, the grant-id type, and default constants for WIDTH and TIMEOUT.
REQ-034 Sub-module rr_arb2 SHALL implement the 2-way round-robin grant: inputs req0, req1, last-grant pointer; output grant id.

Verification
REQ-035 Requester 0 issues 100/7, divider ready after 24 cycles -> ack0 in cycle 2, div_ctrl once, done0 with result=14, exception=0.
REQ-036 req0 and req1 rise in the same cycle after reset, 20/4 and -21/3 -> requester 0 served first (result=5), then requester 1 (result=-7); no overlap of busy periods.
REQ-037 Requester 1 issues 9/0, divider returns exception=1 -> done1 with exception=1; ack0/done0 never asserted.
REQ-038 Reset pulled low 5 cycles into WAIT, then div_ready pulses -> no done, busy=0, all outputs 0, next req0 served normally.
REQ-039 DIV_ARB_TIMEOUT_EN defined, TIMEOUT=32, div_ready held low -> done after 32 WAIT cycles with result=0, exception=1, timeout=1.
REQ-040 Both requesters hold req continuously for 4 operations -> grants strictly alternate 0,1,0,1.
